// File: rtl/somma_1bit.sv
// Unsigned modulo adder with registered side-band copies and a saturating carry counter.
// Optional: define SOMMA_PARITY_EN to add parity / parity_q outputs.
module somma_1bit #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic [WIDTH-1:0] out_q,
    output logic             cout_q,
`ifdef SOMMA_PARITY_EN
    output logic             parity,
    output logic             parity_q,
`endif
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    // Ripple-carry chain; kept clock- and reset-independent so the sum works with clk idle.
    always_comb begin
        carry    = '0;
        sum      = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]     = n1[i] ^ n2[i] ^ carry[i];
            carry[i+1] = (n1[i] & n2[i]) | (carry[i] & (n1[i] ^ n2[i]));
        end
    end

    assign out  = sum;
    assign cout = carry[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out;
            cout_q <= cout;
        end
    end

    // Overflow event counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (cout && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

`ifdef SOMMA_PARITY_EN
    assign parity = ^out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity;
        end
    end
`endif

endmodule

// File: tb/tb_somma_1bit.sv
// Directed bench for somma_1bit: combinational sum, registered copies,
// saturating overflow counter and async reset (three parameterisations).
module tb_somma_1bit;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst    = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0;
    logic       o1, c1, oq1, cq1;
    logic [7:0] cnt1;

    logic       a2 = 1'b0, b2 = 1'b0;
    logic       o2, c2, oq2, cq2;
    logic [1:0] cnt2;

    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic [3:0] o4, oq4;
    logic       c4, cq4;
    logic [7:0] cnt4;

`ifdef SOMMA_PARITY_EN
    logic p1, pq1, p2, pq2, p4, pq4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    somma_1bit #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .n1(a1), .n2(b1), .out(o1), .cout(c1),
        .out_q(oq1), .cout_q(cq1),
`ifdef SOMMA_PARITY_EN
        .parity(p1), .parity_q(pq1),
`endif
        .ovf_cnt(cnt1)
    );

    somma_1bit #(.WIDTH(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .n1(a2), .n2(b2), .out(o2), .cout(c2),
        .out_q(oq2), .cout_q(cq2),
`ifdef SOMMA_PARITY_EN
        .parity(p2), .parity_q(pq2),
`endif
        .ovf_cnt(cnt2)
    );

    somma_1bit #(.WIDTH(4), .CNT_W(8)) u_w4 (
        .clk(clk), .rst(rst), .n1(a4), .n2(b4), .out(o4), .cout(c4),
        .out_q(oq4), .cout_q(cq4),
`ifdef SOMMA_PARITY_EN
        .parity(p4), .parity_q(pq4),
`endif
        .ovf_cnt(cnt4)
    );

    // Gated clock so the combinational path can be checked with clk idle.
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // WIDTH=1 truth table: {n1,n2,out,cout}
    logic [3:0] tt [4] = '{4'b0110, 4'b0000, 4'b1010, 4'b1101};
    logic [1:0] exp_cnt2 [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_out_q",   32'(oq1),  32'd0);
        check("rst_cout_q",  32'(cq1),  32'd0);
        check("rst_ovf_cnt", 32'(cnt1), 32'd0);

        // Combinational truth table, no clock edges, reset held
        for (int i = 0; i < 4; i++) begin
            logic [3:0] v;
            v  = tt[i];
            a1 = v[3];
            b1 = v[2];
            #2;
            check($sformatf("tt%0d_out", i),  32'(o1), 32'(v[1]));
            check($sformatf("tt%0d_cout", i), 32'(c1), 32'(v[0]));
        end

        // Clocked run: w1 gets 3 carry cycles then none, c2 gets 6 carry cycles
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        a2 = 1'b1; b2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) a1 = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                check($sformatf("w1_c%0d_out_q", i),  32'(oq1), 32'd0);
                check($sformatf("w1_c%0d_cout_q", i), 32'(cq1), 32'd1);
                check($sformatf("w1_c%0d_cnt", i),    32'(cnt1), 32'(i + 1));
            end else begin
                check($sformatf("w1_h%0d_out_q", i),  32'(oq1), 32'd1);
                check($sformatf("w1_h%0d_cout_q", i), 32'(cq1), 32'd0);
                check($sformatf("w1_h%0d_cnt", i),    32'(cnt1), 32'd3);
            end
            check($sformatf("c2_sat%0d_cnt", i), 32'(cnt2), 32'(exp_cnt2[i]));
        end

        // Build ovf_cnt=2, then assert reset between edges
        rst = 1'b1;
        #1 rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_cnt", 32'(cnt1), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_cnt",    32'(cnt1), 32'd0);
        check("async_out_q",  32'(oq1),  32'd0);
        check("async_cout_q", 32'(cq1),  32'd0);
        check("async_c2_cnt", 32'(cnt2), 32'd0);
        check("async_out",    32'(o1),   32'd0);
        check("async_cout",   32'(c1),   32'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("resume_out_q",  32'(oq1),  32'd0);
        check("resume_cout_q", 32'(cq1),  32'd1);
        check("resume_cnt",    32'(cnt1), 32'd1);

        // WIDTH=4 wraparound and carry
        a4 = 4'hF; b4 = 4'h1;
        #1;
        check("w4_f1_out",  32'(o4), 32'h0);
        check("w4_f1_cout", 32'(c4), 32'd1);
        @(negedge clk);
        check("w4_f1_out_q",  32'(oq4),  32'h0);
        check("w4_f1_cout_q", 32'(cq4),  32'd1);
        check("w4_f1_cnt",    32'(cnt4), 32'd1);
        a4 = 4'h7; b4 = 4'h8;
        #1;
        check("w4_78_out",  32'(o4), 32'hF);
        check("w4_78_cout", 32'(c4), 32'd0);
        a4 = 4'h9; b4 = 4'h9;
        #1;
        check("w4_99_out",  32'(o4), 32'h2);
        check("w4_99_cout", 32'(c4), 32'd1);
        @(negedge clk);
        check("w4_99_out_q", 32'(oq4),  32'h2);
        check("w4_99_cnt",   32'(cnt4), 32'd2);

`ifdef SOMMA_PARITY_EN
        a4 = 4'h3; b4 = 4'h4;
        #1;
        check("par_out", 32'(o4), 32'h7);
        check("par",     32'(p4), 32'd1);
        check("par_q_pre", 32'(pq4), 32'd1);
        @(negedge clk);
        check("par_q", 32'(pq4), 32'd1);
        a4 = 4'h1; b4 = 4'h2;
        @(negedge clk);
        check("par_q_even", 32'(pq4), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
